ai_target_select: RTL and testbench

- Consumer of the probability-density map produced by the battleship AI density engine.
- On `start`, snapshots the 100-cell density map and fired mask, scans one cell per cycle, and selects the highest-density unfired cell.
- Presents that cell through a valid/ready handshake to the game controller as the next shot (linear index plus row/column).

---
 rtl/ai_pkg.sv | 22 ++
 rtl/ai_max_tracker.sv | 38 +++
 rtl/ai_target_select.sv | 107 ++++++++++
 tb/tb_ai_target_select.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ai_pkg.sv
// Shared constants and types for the battleship AI target selector.
package ai_pkg;

  localparam int CELLS = 100;
  localparam int GRID  = 10;
  localparam int DW    = 6;
  localparam int IW    = $clog2(CELLS);

  typedef logic [DW-1:0]        dens_t;
  typedef dens_t [CELLS-1:0]    dens_map_t;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} sel_state_t;

  typedef struct packed {
    logic          found;
    dens_t         val;
    logic [IW-1:0] idx;
    logic [3:0]    row;
    logic [3:0]    col;
  } best_t;

endpackage

// File: rtl/ai_max_tracker.sv
// Running maximum over scanned cells; ties keep the earliest (lowest-index) cell.
module ai_max_tracker
  import ai_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          en,
  input  logic          cand,
  input  dens_t         val,
  input  logic [IW-1:0] idx,
  input  logic [3:0]    row,
  input  logic [3:0]    col,
  output best_t         best_nxt
);

  best_t best_q;

  // The next value is exported so the final cell's update is visible on the scan's last edge.
  always_comb begin
    best_nxt = best_q;
    if (clear) begin
      best_nxt = '0;
    end else if (en && cand && (!best_q.found || val > best_q.val)) begin
      best_nxt.found = 1'b1;
      best_nxt.val   = val;
      best_nxt.idx   = idx;
      best_nxt.row   = row;
      best_nxt.col   = col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) best_q <= '0;
    else        best_q <= best_nxt;
  end

endmodule

// File: rtl/ai_target_select.sv
// Snapshots the density map on start, scans one cell per cycle and offers the
// densest unfired cell as the next shot over a valid/ready handshake.
module ai_target_select
  import ai_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  dens_map_t             density,
  input  logic [CELLS-1:0]      fired,
  output logic                  busy,
  output logic                  target_valid,
  input  logic                  target_ready,
  output logic [IW-1:0]         target_idx,
  output logic [3:0]            target_row,
  output logic [3:0]            target_col,
  output dens_t                 target_density,
  output logic                  no_target
);

  sel_state_t       state;
  dens_map_t        dens_q;
  logic [CELLS-1:0] fired_q;
  logic [IW-1:0]    idx_cnt;
  logic [3:0]       row_cnt;
  logic [3:0]       col_cnt;
  best_t            best_nxt;
  logic             trk_clear;
  logic             trk_en;

  assign trk_clear = (state == IDLE) && start;
  assign trk_en    = (state == SCAN);

  ai_max_tracker u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (trk_clear),
    .en       (trk_en),
    .cand     (!fired_q[idx_cnt]),
    .val      (dens_q[idx_cnt]),
    .idx      (idx_cnt),
    .row      (row_cnt),
    .col      (col_cnt),
    .best_nxt (best_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dens_q         <= '0;
      fired_q        <= '0;
      idx_cnt        <= '0;
      row_cnt        <= '0;
      col_cnt        <= '0;
      busy           <= 1'b0;
      target_valid   <= 1'b0;
      target_idx     <= '0;
      target_row     <= '0;
      target_col     <= '0;
      target_density <= '0;
      no_target      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dens_q  <= density;
            fired_q <= fired;
            idx_cnt <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (idx_cnt == IW'(CELLS - 1)) begin
            // Counter stops at the last cell; leaving SCAN is what bounds it.
            target_valid   <= 1'b1;
            target_idx     <= best_nxt.idx;
            target_row     <= best_nxt.row;
            target_col     <= best_nxt.col;
            target_density <= best_nxt.val;
            no_target      <= !best_nxt.found;
            state          <= HOLD;
          end else begin
            idx_cnt <= idx_cnt + 1'b1;
            if (col_cnt == 4'(GRID - 1)) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (target_ready) begin
            target_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_target_select.sv
// Randomised and directed self-checking bench for ai_target_select.
module tb_ai_target_select;
  import ai_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             target_ready = 1'b0;
  dens_map_t        density = '0;
  logic [CELLS-1:0] fired = '0;
  logic             busy, target_valid, no_target;
  logic [IW-1:0]    target_idx;
  logic [3:0]       target_row, target_col;
  dens_t            target_density;

  int checks = 0;
  int errors = 0;

  bit e_none;
  int e_idx, e_val;

  always #5 clk = ~clk;

  ai_target_select dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .density        (density),
    .fired          (fired),
    .busy           (busy),
    .target_valid   (target_valid),
    .target_ready   (target_ready),
    .target_idx     (target_idx),
    .target_row     (target_row),
    .target_col     (target_col),
    .target_density (target_density),
    .no_target      (no_target)
  );

  // Reference: highest density among unfired cells, lowest index on a tie.
  function automatic void ref_pick(input dens_map_t d, input logic [CELLS-1:0] f,
                                   output bit none, output int idx, output int val);
    int mx = -1;
    for (int i = 0; i < CELLS; i++)
      if (!f[i] && int'(d[i]) > mx) mx = int'(d[i]);
    none = (mx < 0);
    idx  = 0;
    val  = 0;
    if (!none) begin
      val = mx;
      for (int i = CELLS - 1; i >= 0; i--)
        if (!f[i] && int'(d[i]) == mx) idx = i;
    end
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (target_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    @(negedge clk) target_ready = 1'b1;
    @(negedge clk) target_ready = 1'b0;
  endtask

  task automatic randomize_map(input int maxv, input int fire_pct);
    for (int i = 0; i < CELLS; i++) begin
      density[i] = DW'($urandom_range(0, maxv));
      fired[i]   = ($urandom_range(0, 99) < fire_pct);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, target_valid, target_idx, target_row, target_col, target_density, no_target} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0d valid=%0d idx=%0d row=%0d col=%0d dens=%0d none=%0d expected all 0",
               busy, target_valid, target_idx, target_row, target_col, target_density, no_target);
    end
  endtask

  task automatic test_single_peak();
    int lat;
    density = '0;
    fired   = '0;
    density[57] = 6'd33;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL peak_busy: got %0d expected 1", busy);
    end
    wait_valid(lat);
    // Registered on the 100th edge after start, so a sampler at edge t+101 first sees it.
    checks++;
    if (lat != 100) begin
      errors++;
      $display("FAIL peak_latency: got %0d edges expected 100", lat);
    end
    checks++;
    if ({no_target, target_idx, target_row, target_col, target_density} !== {1'b0, 7'd57, 4'd5, 4'd7, 6'd33}) begin
      errors++;
      $display("FAIL peak_result: got none=%0d idx=%0d row=%0d col=%0d dens=%0d expected none=0 idx=57 row=5 col=7 dens=33",
               no_target, target_idx, target_row, target_col, target_density);
    end
    accept();
  endtask

  task automatic test_tie();
    int lat;
    for (int i = 0; i < CELLS; i++) density[i] = 6'd10;
    fired = '0;
    density[12] = 6'd63;
    density[88] = 6'd63;
    pulse_start();
    wait_valid(lat);
    checks++;
    if (target_valid !== 1'b1 || {target_idx, target_row, target_col, target_density} !== {7'd12, 4'd1, 4'd2, 6'd63}) begin
      errors++;
      $display("FAIL tie_result: got valid=%0d idx=%0d row=%0d col=%0d dens=%0d expected valid=1 idx=12 row=1 col=2 dens=63",
               target_valid, target_idx, target_row, target_col, target_density);
    end
    accept();
  endtask

  task automatic test_fired_mask();
    int lat;
    density = '0;
    fired   = '0;
    density[57] = 6'd63;
    fired[57]   = 1'b1;
    density[3]  = 6'd40;
    pulse_start();
    wait_valid(lat);
    checks++;
    if (target_valid !== 1'b1 || {no_target, target_idx, target_density} !== {1'b0, 7'd3, 6'd40}) begin
      errors++;
      $display("FAIL mask_result: got valid=%0d none=%0d idx=%0d dens=%0d expected valid=1 none=0 idx=3 dens=40",
               target_valid, no_target, target_idx, target_density);
    end
    accept();
  endtask

  task automatic test_all_fired();
    int lat;
    randomize_map(63, 0);
    fired = '1;
    pulse_start();
    wait_valid(lat);
    checks++;
    if (lat != 100) begin
      errors++;
      $display("FAIL allfired_latency: got %0d edges expected 100", lat);
    end
    checks++;
    if ({no_target, target_idx, target_row, target_col, target_density} !== {1'b1, 7'd0, 4'd0, 4'd0, 6'd0}) begin
      errors++;
      $display("FAIL allfired_result: got none=%0d idx=%0d row=%0d col=%0d dens=%0d expected none=1 idx=0 row=0 col=0 dens=0",
               no_target, target_idx, target_row, target_col, target_density);
    end
    accept();
  endtask

  task automatic test_handshake_robust();
    int lat;
    int bad = 0;
    randomize_map(63, 30);
    ref_pick(density, fired, e_none, e_idx, e_val);
    pulse_start();
    repeat (30) @(negedge clk);
    randomize_map(63, 0);
    wait_valid(lat);
    checks++;
    if (target_valid !== 1'b1 || {no_target, target_idx, target_row, target_col, target_density} !==
        {e_none, IW'(e_idx), 4'(e_idx / GRID), 4'(e_idx % GRID), DW'(e_val)}) begin
      errors++;
      $display("FAIL midscan_result: got valid=%0d none=%0d idx=%0d row=%0d col=%0d dens=%0d expected none=%0d idx=%0d row=%0d col=%0d dens=%0d",
               target_valid, no_target, target_idx, target_row, target_col, target_density,
               e_none, e_idx, e_idx / GRID, e_idx % GRID, e_val);
    end
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (target_valid !== 1'b1 || busy !== 1'b1 || target_idx !== IW'(e_idx) || target_density !== DW'(e_val)) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d got valid=%0d busy=%0d idx=%0d dens=%0d expected valid=1 busy=1 idx=%0d dens=%0d",
                 c, target_valid, busy, target_idx, target_density, e_idx, e_val);
      end
    end
    target_ready = 1'b1;
    @(negedge clk);
    target_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (target_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake_drop: got valid=%0d busy=%0d expected 0 0", target_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || target_idx !== IW'(e_idx)) begin
      errors++;
      $display("FAIL handshake_noqueue: got busy=%0d idx=%0d expected busy=0 idx=%0d", busy, target_idx, e_idx);
    end
    if (bad != 0) errors++;
  endtask

  task automatic test_back_to_back();
    int lat;
    randomize_map(7, 20);
    ref_pick(density, fired, e_none, e_idx, e_val);
    pulse_start();
    wait_valid(lat);
    @(negedge clk) target_ready = 1'b1;
    @(negedge clk) begin
      target_ready = 1'b0;
      randomize_map(63, 50);
      start = 1'b1;
    end
    ref_pick(density, fired, e_none, e_idx, e_val);
    @(negedge clk) start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%0d expected 1", busy);
    end
    wait_valid(lat);
    checks++;
    if (lat != 100 || {no_target, target_idx, target_row, target_col, target_density} !==
        {e_none, IW'(e_idx), 4'(e_idx / GRID), 4'(e_idx % GRID), DW'(e_val)}) begin
      errors++;
      $display("FAIL b2b_result: got lat=%0d none=%0d idx=%0d dens=%0d expected lat=100 none=%0d idx=%0d dens=%0d",
               lat, no_target, target_idx, target_density, e_none, e_idx, e_val);
    end
    accept();
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 6; n++) begin
      randomize_map((n % 2 == 0) ? 3 : 63, (n < 3) ? 10 * n : 90 + n);
      ref_pick(density, fired, e_none, e_idx, e_val);
      pulse_start();
      wait_valid(lat);
      checks++;
      if (target_valid !== 1'b1 || {no_target, target_idx, target_row, target_col, target_density} !==
          {e_none, IW'(e_idx), 4'(e_idx / GRID), 4'(e_idx % GRID), DW'(e_val)}) begin
        errors++;
        $display("FAIL random_%0d: got valid=%0d none=%0d idx=%0d row=%0d col=%0d dens=%0d expected none=%0d idx=%0d row=%0d col=%0d dens=%0d",
                 n, target_valid, no_target, target_idx, target_row, target_col, target_density,
                 e_none, e_idx, e_idx / GRID, e_idx % GRID, e_val);
      end
      accept();
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    randomize_map(63, 10);
    pulse_start();
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, target_valid, target_idx, target_density, no_target} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%0d valid=%0d idx=%0d dens=%0d none=%0d expected all 0",
               busy, target_valid, target_idx, target_density, no_target);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || target_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got busy=%0d valid=%0d expected 0 0", busy, target_valid);
    end
    density = '0;
    fired   = '0;
    density[99] = 6'd1;
    pulse_start();
    wait_valid(lat);
    checks++;
    if (target_valid !== 1'b1 || {no_target, target_idx, target_row, target_col, target_density} !== {1'b0, 7'd99, 4'd9, 4'd9, 6'd1}) begin
      errors++;
      $display("FAIL midreset_rescan: got valid=%0d none=%0d idx=%0d row=%0d col=%0d dens=%0d expected none=0 idx=99 row=9 col=9 dens=1",
               target_valid, no_target, target_idx, target_row, target_col, target_density);
    end
    accept();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_peak();
    test_tie();
    test_fired_mask();
    test_all_fired();
    test_handshake_robust();
    test_back_to_back();
    test_random();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
